// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2 memory-side burst sequencer and its arbiter.
package l2_mem_pkg;

   // Burst sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   // Requester identities, also used as the round-robin history value
   typedef enum logic {
      REQ_FILL = 1'b0,
      REQ_WB   = 1'b1
   } req_id_t;

   // Line geometry defaults shared with the L2 controller
   localparam int unsigned L2_BURST_LEN   = 8;
   localparam int unsigned L2_OFFSET_BITS = 6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted
// last wins; the history updates whenever a grant is taken.
module rr_arb2
   import l2_mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req_fill,
   input  logic i_req_wb,
   input  logic i_update,
   output logic o_gnt_fill,
   output logic o_gnt_wb
);

   req_id_t r_last;
   logic    w_pick_fill;

   assign w_pick_fill = i_req_fill && (!i_req_wb || (r_last == REQ_WB));
   assign o_gnt_fill  = w_pick_fill;
   assign o_gnt_wb    = i_req_wb && !w_pick_fill;

   // Grant history; starts at WB so the first tie goes to the fill engine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= REQ_WB;
      end else if (i_update && (o_gnt_fill || o_gnt_wb)) begin
         r_last <= o_gnt_wb ? REQ_WB : REQ_FILL;
      end
   end

endmodule

// File: rtl/l2_mem_burst_ctrl.sv
// L2 <-> main-memory burst sequencer: arbitrates line fills and writebacks
// and runs one fixed-length burst at a time with a bus-idle timeout.
module l2_mem_burst_ctrl
   import l2_mem_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH  = 32,
   parameter  int unsigned DATA_WIDTH  = 64,
   parameter  int unsigned BURST_LEN   = L2_BURST_LEN,
   parameter  int unsigned OFFSET_BITS = L2_OFFSET_BITS,
   parameter  int unsigned TIMEOUT     = 255,
   localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fill_req,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   output logic                  fill_gnt,
   output logic                  fill_valid,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic [BEAT_W-1:0]     fill_beat,
   output logic                  fill_done,
   input  logic                  wb_req,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_gnt,
   output logic [BEAT_W-1:0]     wb_beat,
   output logic                  wb_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  bus_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

   state_t                r_state, w_next;
   logic                  w_gnt_fill, w_gnt_wb, w_grant;
   logic                  w_last_beat, w_timeout;
   logic [BEAT_W-1:0]     r_beat;
   logic [TMO_W-1:0]      r_tmo;
   logic                  r_fill_gnt, r_wb_gnt, r_mem_req, r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_fill_valid, r_fill_done, r_wb_done, r_bus_err;
   logic [DATA_WIDTH-1:0] r_fill_data;
   logic [BEAT_W-1:0]     r_fill_beat;

   rr_arb2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req_fill (fill_req),
      .i_req_wb   (wb_req),
      .i_update   (w_grant),
      .o_gnt_fill (w_gnt_fill),
      .o_gnt_wb   (w_gnt_wb)
   );

   assign w_grant     = (r_state == IDLE) && (w_gnt_fill || w_gnt_wb);
   assign w_last_beat = mem_ack && (r_beat == BEAT_W'(BURST_LEN - 1));
   assign w_timeout   = !mem_ack && (r_tmo == TMO_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state: grant -> transfer -> one-cycle done -> idle
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_grant) w_next = XFER;
         XFER:    if (w_last_beat || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Burst datapath: grant capture, beat/timeout counting, read beats, done pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill_gnt   <= 1'b0;
         r_wb_gnt     <= 1'b0;
         r_mem_req    <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_beat       <= '0;
         r_tmo        <= '0;
         r_fill_valid <= 1'b0;
         r_fill_data  <= '0;
         r_fill_beat  <= '0;
         r_fill_done  <= 1'b0;
         r_wb_done    <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_fill_valid <= 1'b0;
         r_fill_done  <= 1'b0;
         r_wb_done    <= 1'b0;
         r_bus_err    <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_fill_gnt <= w_gnt_fill;
                  r_wb_gnt   <= w_gnt_wb;
                  r_mem_req  <= 1'b1;
                  r_we       <= w_gnt_wb;
                  r_addr     <= (w_gnt_wb ? wb_addr : fill_addr) & ALIGN_MASK;
                  r_beat     <= '0;
                  r_tmo      <= '0;
               end
            end
            XFER: begin
               if (mem_ack) begin
                  r_beat <= r_beat + 1'b1;
                  r_tmo  <= '0;
                  if (!r_we) begin
                     r_fill_valid <= 1'b1;
                     r_fill_data  <= mem_rdata;
                     r_fill_beat  <= r_beat;
                  end
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
               if (w_last_beat || w_timeout) begin
                  r_mem_req   <= 1'b0;
                  r_fill_done <= r_fill_gnt;
                  r_wb_done   <= r_wb_gnt;
                  r_bus_err   <= w_timeout;
               end
            end
            DONE: begin
               r_fill_gnt <= 1'b0;
               r_wb_gnt   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign fill_gnt   = r_fill_gnt;
   assign fill_valid = r_fill_valid;
   assign fill_data  = r_fill_data;
   assign fill_beat  = r_fill_beat;
   assign fill_done  = r_fill_done;
   assign wb_gnt     = r_wb_gnt;
   assign wb_beat    = r_beat;
   assign wb_done    = r_wb_done;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_wdata  = ((r_state == XFER) && r_we) ? wb_data : '0;
   assign bus_err    = r_bus_err;

endmodule

// File: doc/l2_mem_burst_ctrl.md
Name: l2_mem_burst_ctrl

Overview:
- Sequences all traffic between the L2 cache and main memory over the shared 64-bit memory port.
- Arbitrates between two requesters:
  - L2 line-fill engine: burst read on a miss.
  - L2 writeback engine: burst write of a dirty victim.
- Runs one fixed-length burst at a time and reports per-beat data, completion and a bus-timeout error to the granted requester.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, memory beat width in bits
BURST_LEN, 8, beats per line transfer (power of 2)
OFFSET_BITS, 6, log2(BURST_LEN*DATA_WIDTH/8); line-offset bits forced to zero on mem_addr
TIMEOUT, 255, max idle cycles waiting for mem_ack before abort

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fill_req  in  1  fill burst request, held until fill_done
fill_addr  in  ADDR_WIDTH  fill line address (sampled at grant)
fill_gnt  out  1  fill owns memory port (grant through done)
fill_valid  out  1  fill_data holds a valid beat
fill_data  out  DATA_WIDTH  read beat
fill_beat  out  log2(BURST_LEN)  index of the beat on fill_data
fill_done  out  1  one-cycle burst-complete pulse
wb_req  in  1  writeback burst request, held until wb_done
wb_addr  in  ADDR_WIDTH  victim line address (sampled at grant)
wb_data  in  DATA_WIDTH  write beat for index wb_beat, driven same cycle
wb_gnt  out  1  writeback owns memory port
wb_beat  out  log2(BURST_LEN)  beat index requested from writeback engine
wb_done  out  1  one-cycle burst-complete pulse
mem_req  out  1  burst active toward memory
mem_we  out  1  1 = write burst, 0 = read burst
mem_addr  out  ADDR_WIDTH  line-aligned address, constant for whole burst
mem_wdata  out  DATA_WIDTH  write beat
mem_rdata  in  DATA_WIDTH  read beat, valid when mem_ack
mem_ack  in  1  one beat transferred this cycle
bus_err  out  1  one-cycle pulse coincident with done when burst aborted by timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, beat counter 0, timeout counter 0, last_grant=WB (first tie goes to fill). mem_req drops immediately even mid-burst; no done pulse is generated.
- States: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin), then update last_grant.
  - On grant edge:
    - Latch address with bits [OFFSET_BITS-1:0] cleared; set mem_we (1 for WB).
    - Assert the requester's gnt and mem_req; go to XFER.
  - Grant-to-mem_req latency: 1 cycle after req seen.
- XFER:
  - Each cycle with mem_ack=1 advances the beat counter; the counter resets the timeout counter.
  - Write:
    - mem_wdata = wb_data combinationally.
    - wb_beat = current counter; advances after each ack.
  - Read:
    - fill_data/fill_beat registered from mem_rdata/counter.
    - fill_valid pulses 1 cycle after each ack.
  - Ack on beat BURST_LEN-1: deassert mem_req next cycle, go to DONE.
  - Cycles without ack increment the timeout counter. Reaching TIMEOUT: drop mem_req, go to DONE with error flag set.
- DONE (one cycle):
  - Pulse the granted requester's done; pulse bus_err if aborted.
  - Deassert gnt at the end of the cycle; return to IDLE.
  - A new grant is possible on the following cycle (minimum 1 idle cycle between bursts).
- Requester deasserting req mid-burst is ignored: the burst always completes or times out. req still high at the IDLE re-entry counts as a new request.
- mem_ack outside XFER is ignored.
- The final read beat's fill_valid coincides with fill_done.
- fill_gnt and wb_gnt are never both 1. mem_addr, mem_we are stable while mem_req=1.

Decomposition:
- Package l2_mem_pkg:
  - State enum: IDLE, XFER, DONE.
  - Requester ID constants: REQ_FILL, REQ_WB.
  - Shared BURST_LEN/OFFSET_BITS defaults, shared with the L2 controller.
- Sub-module rr_arb2: 2-way round-robin arbiter with a last_grant register and an update-on-grant input.

Test Plan:
- Fill only, fill_addr=0x0000_1234, mem_ack every cycle with rdata=beat index -> mem_addr=0x0000_1200, mem_we=0, 8 fill_valid pulses with data 0..7, fill_done on the cycle after the last ack, 1 idle cycle.
- WB only, wb_addr=0x0000_40FF, wb_data=0xA5A5_0000_0000_0000+wb_beat, acks every other cycle -> mem_addr=0x0000_40C0, mem_we=1, mem_wdata sequence ...00..07, wb_done after the 8th ack, 16-cycle burst.
- Both req high from reset -> fill granted first, then WB, then fill again if re-requested; never both gnt.
- mem_ack stuck low after beat 3, TIMEOUT=255 -> mem_req drops at the 255th idle cycle, done and bus_err pulse together, next request serviced normally.
- rst_n low during beat 5 of a write -> mem_req, wb_gnt 0 asynchronously, no wb_done; after release, held wb_req is re-granted from beat 0.
- fill_req deasserted at beat 2 -> burst still completes all 8 beats with fill_done.
